// File: rtl/shift_frame_engine_if.sv
// Control/data bundle for the shift frame engine; master drives strobe, mode
// and data, slave returns register contents, serial output and frame status.
interface shift_frame_engine_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             serialClkposedge;
  logic [1:0]       mode;
  logic [WIDTH-1:0] parallelIn;
  logic             serialIn;
  logic [WIDTH-1:0] parallelOut;
  logic             serialOut;
  logic [CW-1:0]    bitCount;
  logic             busy;
  logic             frameDone;
  logic             frameAbort;

  modport master (
    output serialClkposedge, mode, parallelIn, serialIn,
    input  parallelOut, serialOut, bitCount, busy, frameDone, frameAbort
  );

  modport slave (
    input  serialClkposedge, mode, parallelIn, serialIn,
    output parallelOut, serialOut, bitCount, busy, frameDone, frameAbort
  );
endinterface

// File: rtl/shift_frame_engine.sv
// Strobed left/right shift register with WIDTH-shift framing; outputs are 1-cycle registered.
// No backpressure: every strobed edge is accepted; frameDone/frameAbort are single-cycle pulses.
module shift_frame_engine #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_frame_engine_if.slave   bus
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_PLOAD = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_RIGHT = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic { ST_IDLE, ST_ACTIVE } state_t;
  typedef enum logic { DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1 } dir_t;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             is_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_LEFT;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    is_shift = 1'b0;

    if (bus.serialClkposedge) begin
      case (bus.mode)
        MODE_PLOAD: begin
          sreg_d  = bus.parallelIn;
          cnt_d   = '0;
          abort_d = (state_q == ST_ACTIVE);
          state_d = ST_IDLE;
        end
        MODE_LEFT: begin
          sreg_d   = {sreg_q[WIDTH-2:0], bus.serialIn};
          dir_d    = DIR_LEFT;
          is_shift = 1'b1;
        end
        MODE_RIGHT: begin
          sreg_d   = {bus.serialIn, sreg_q[WIDTH-1:1]};
          dir_d    = DIR_RIGHT;
          is_shift = 1'b1;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end

    // Both directions count toward the same frame; the last shift closes it.
    if (is_shift) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = ST_ACTIVE;
      end
    end
  end

  assign bus.parallelOut = sreg_q;
  assign bus.serialOut   = (dir_q == DIR_RIGHT) ? sreg_q[0] : sreg_q[WIDTH-1];
  assign bus.bitCount    = cnt_q;
  assign bus.busy        = (cnt_q != '0);
  assign bus.frameDone   = done_q;
  assign bus.frameAbort  = abort_q;

endmodule

// File: doc/shift_frame_engine.md
SHIFT_FRAME_ENGINE -- requirements
Module: shift_frame_engine

Interface
REQ-001 Parameter WIDTH, default 8, shift register width in bits (legal range 2..32).
REQ-002 Parameter CW, default $clog2(WIDTH+1), bit-counter width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 serialClkposedge  input  1  shift/load strobe; state advances only on clk edges where it is 1.
REQ-006 mode  input  2  operation: HOLD=2'b00, PLOAD=2'b01, LEFT=2'b10, RIGHT=2'b11.
REQ-007 parallelIn  input  WIDTH  parallel load data.
REQ-008 serialIn  input  1  serial data shifted into the vacated end.
REQ-009 parallelOut  output  WIDTH  current register contents.
REQ-010 serialOut  output  1  bit at the exit end for the last shift direction.
REQ-011 bitCount  output  CW  shifts completed in the current frame, 0..WIDTH-1.
REQ-012 busy  output  1  high while bitCount != 0 (frame in progress).
REQ-013 frameDone  output  1  one-cycle pulse: WIDTH-th shift of a frame completed.
REQ-014 frameAbort  output  1  one-cycle pulse: PLOAD accepted while busy.

Function
REQ-015 Strobe low: register, bitCount, direction flag held; frameDone/frameAbort deassert next edge.
REQ-016 Strobe high, HOLD: no state change; bitCount held (frame paused, not cleared).
REQ-017 Strobe high, PLOAD: register <= parallelIn, bitCount <= 0, same edge.
REQ-018 Strobe high, LEFT: register <= {register[WIDTH-2:0], serialIn}; dir flag <= LEFT.
REQ-019 Strobe high, RIGHT: register <= {serialIn, register[WIDTH-1:1]}; dir flag <= RIGHT.
REQ-020 serialOut = register[WIDTH-1] when dir flag LEFT, register[0] when RIGHT; combinational from registers only, no dependence on current mode input.
REQ-021 Each LEFT/RIGHT strobe increments bitCount; on the shift where bitCount == WIDTH-1, bitCount wraps to 0 and frameDone = 1 for exactly the following cycle.
REQ-022 Direction change mid-frame (LEFT<->RIGHT) does not clear bitCount; both count toward the frame.
REQ-023 Frame FSM: IDLE (bitCount==0) -> ACTIVE on first shift; ACTIVE -> IDLE on WIDTH-th shift (frameDone) or PLOAD (frameAbort); PLOAD in IDLE stays IDLE, no pulse.
REQ-024 frameAbort asserts for one cycle only when PLOAD is accepted in ACTIVE; never together with frameDone.
REQ-025 Back-to-back strobes on consecutive clk edges fully supported; zero-bubble frames (frameDone cycle may accept next shift).
REQ-026 Latency: parallelOut/serialOut/bitCount reflect an accepted strobe immediately after that clk edge (1-cycle registered).
REQ-027 Undriven (X) serialIn is shifted as-is; no internal sanitising.

Reset
REQ-028 rst_n low asynchronously forces: parallelOut=0, bitCount=0, busy=0, frameDone=0, frameAbort=0, dir flag=LEFT, serialOut=0, FSM=IDLE.
REQ-029 Reset asserted mid-frame discards the frame with no frameDone/frameAbort pulse; first edge after rst_n rises with strobe high is processed normally.

Verification (WIDTH=8 unless stated)
REQ-030 PLOAD 8'hA5, then 8 LEFT strobes with serialIn=1 -> serialOut before each shift 1,0,1,0,0,1,0,1; final parallelOut=8'hFF; bitCount 1..7 then 0; frameDone high exactly one cycle after 8th shift.
REQ-031 PLOAD 8'h00, RIGHT strobes serialIn=1,0,1,0,1,0,0,0 -> parallelOut=8'b00010101 after 8th shift; serialOut=register[0] each step; frameDone pulse once.
REQ-032 PLOAD 8'h7F, HOLD and strobe-low cycles with varying serialIn/parallelIn -> parallelOut stays 8'h7F, bitCount unchanged, no pulses.
REQ-033 PLOAD, 3 LEFT shifts, PLOAD 8'h3C -> frameAbort one cycle, bitCount=0, busy=0, parallelOut=8'h3C.
REQ-034 4 LEFT shifts then rst_n low between edges -> outputs zero immediately (no clock), no pulses; subsequent full frame completes normally.
REQ-035 WIDTH=16: PLOAD 16'h8001, 16 LEFT shifts serialIn=0 -> parallelOut=0, frameDone after 16th shift only; 4 RIGHT + 12 LEFT also yields one frameDone.
